// File: rtl/stage_mem_pkg.sv
// Shared pipeline types for the MIPS memory stage: control bundle, EX/MEM and MEM/WB latches.
// Optional byte/halfword-free byte access is enabled with STAGE_MEM_BYTE_EN.
package stage_mem_pkg;

  localparam int DATA_W = 32;

  typedef struct packed {
    logic memRead;
    logic memWrite;
    logic branch;
    logic memtoReg;
    logic regWrite;
`ifdef STAGE_MEM_BYTE_EN
    logic memByte;
    logic memUnsigned;
`endif
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef struct packed {
    ctrl_t              ctrl;
    logic               zero;
    logic [DATA_W-1:0]  aluOut;
    logic [DATA_W-1:0]  addEx;
    logic [DATA_W-1:0]  rtData;
    logic [4:0]         writeReg;
  } exMem_t;

  typedef struct packed {
    logic               regWrite;
    logic               memtoReg;
    logic [4:0]         writeReg;
    logic [DATA_W-1:0]  aluOut;
`ifdef STAGE_MEM_BYTE_EN
    logic               memByte;
    logic               memUnsigned;
    logic [1:0]         lane;
`endif
  } memWb_t;

`ifdef STAGE_MEM_BYTE_EN
  // Picks the addressed byte lane out of a RAM word and extends it to 32 bits.
  function automatic logic [DATA_W-1:0] loadExtend(input logic [DATA_W-1:0] word,
                                                   input logic [1:0] lane,
                                                   input logic isByte,
                                                   input logic isUnsigned);
    logic signed [7:0]        b;
    logic signed [DATA_W-1:0] sext;
    b    = word[8*lane +: 8];
    sext = DATA_W'(b);
    if (!isByte)        return word;
    else if (isUnsigned) return {24'd0, b};
    else                 return sext;
  endfunction
`endif

endpackage

// File: rtl/stage_mem_data_mem.sv
// Synchronous-read data RAM with a per-byte write mask; read data is registered.
module data_mem #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              re,
  input  logic              we,
  input  logic [3:0]        byteMask,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we && byteMask[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // Output register doubles as the read-data field of the MEM/WB latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/stage_mem.sv
// MIPS memory stage: EX/MEM latch, branch resolve, data RAM access, MEM/WB latch.
// Define STAGE_MEM_BYTE_EN to add byte loads/stores (memByte, memUnsigned ports).
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] outAlu,
  input  logic        zeroAlu,
  input  logic [31:0] outAddEx,
  input  logic [31:0] readRt,
  input  logic [4:0]  writeReg,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Branch,
  input  logic        MemtoReg,
  input  logic        RegWrite,
`ifdef STAGE_MEM_BYTE_EN
  input  logic        memByte,
  input  logic        memUnsigned,
`endif
  input  logic        flush,
  output logic        pcSrc,
  output logic [31:0] branchTarget,
  output logic        exMemRegWrite,
  output logic [4:0]  exMemWriteReg,
  output logic [31:0] exMemAluOut,
  output logic [31:0] wbData,
  output logic [4:0]  wbReg,
  output logic        wbRegWrite
);

  ctrl_t       ctrlCap;
  exMem_t      exMem_p0;
  memWb_t      memWb_p1;
  memWb_t      memWbNext;
  logic [31:0] ramData_p1;
  logic [3:0]  ramMask;
  logic [31:0] ramWdata;

  // A flushed instruction keeps its data but loses every side-effecting control bit.
  always_comb begin
    ctrlCap.memRead  = MemRead;
    ctrlCap.memWrite = MemWrite;
    ctrlCap.branch   = Branch;
    ctrlCap.memtoReg = MemtoReg;
    ctrlCap.regWrite = RegWrite;
`ifdef STAGE_MEM_BYTE_EN
    ctrlCap.memByte     = memByte;
    ctrlCap.memUnsigned = memUnsigned;
`endif
    if (flush) begin
      ctrlCap.memRead  = CTRL_BUBBLE.memRead;
      ctrlCap.memWrite = CTRL_BUBBLE.memWrite;
      ctrlCap.branch   = CTRL_BUBBLE.branch;
      ctrlCap.regWrite = CTRL_BUBBLE.regWrite;
    end
  end

  // ---- EX/MEM boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exMem_p0 <= '0;
    end else begin
      exMem_p0.ctrl     <= ctrlCap;
      exMem_p0.zero     <= zeroAlu;
      exMem_p0.aluOut   <= outAlu;
      exMem_p0.addEx    <= outAddEx;
      exMem_p0.rtData   <= readRt;
      exMem_p0.writeReg <= writeReg;
    end
  end

  assign pcSrc         = exMem_p0.ctrl.branch & exMem_p0.zero;
  assign branchTarget  = exMem_p0.addEx;
  assign exMemRegWrite = exMem_p0.ctrl.regWrite;
  assign exMemWriteReg = exMem_p0.writeReg;
  assign exMemAluOut   = exMem_p0.aluOut;

`ifdef STAGE_MEM_BYTE_EN
  always_comb begin
    if (exMem_p0.ctrl.memByte) begin
      ramMask  = 4'b0001 << exMem_p0.aluOut[1:0];
      ramWdata = {4{exMem_p0.rtData[7:0]}};
    end else begin
      ramMask  = 4'b1111;
      ramWdata = exMem_p0.rtData;
    end
  end
`else
  assign ramMask  = 4'b1111;
  assign ramWdata = exMem_p0.rtData;
`endif

  data_mem #(.ADDR_W(ADDR_W)) uRam (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (exMem_p0.aluOut[ADDR_W+1:2]),
    .re       (exMem_p0.ctrl.memRead),
    .we       (exMem_p0.ctrl.memWrite),
    .byteMask (ramMask),
    .wdata    (ramWdata),
    .rdata    (ramData_p1)
  );

  always_comb begin
    memWbNext.regWrite = exMem_p0.ctrl.regWrite;
    memWbNext.memtoReg = exMem_p0.ctrl.memtoReg;
    memWbNext.writeReg = exMem_p0.writeReg;
    memWbNext.aluOut   = exMem_p0.aluOut;
`ifdef STAGE_MEM_BYTE_EN
    memWbNext.memByte     = exMem_p0.ctrl.memByte;
    memWbNext.memUnsigned = exMem_p0.ctrl.memUnsigned;
    memWbNext.lane        = exMem_p0.aluOut[1:0];
`endif
  end

  // ---- MEM/WB boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) memWb_p1 <= '0;
    else        memWb_p1 <= memWbNext;
  end

`ifdef STAGE_MEM_BYTE_EN
  assign wbData = memWb_p1.memtoReg
                ? loadExtend(ramData_p1, memWb_p1.lane, memWb_p1.memByte, memWb_p1.memUnsigned)
                : memWb_p1.aluOut;
`else
  assign wbData = memWb_p1.memtoReg ? ramData_p1 : memWb_p1.aluOut;
`endif
  assign wbReg      = memWb_p1.writeReg;
  assign wbRegWrite = memWb_p1.regWrite;

endmodule
